usb_pkt_serializer: RTL and testbench
=====================================

// Module: usb_pkt_serializer
// PURPOSE
//  Parametrised USB packet serializer: next-generation bitstream encoder between the protocol FSM and the bit stuffer.
//  Builds SYNC + PID/~PID + payload + CRC for handshake, token and variable-length data packets.
//  Streams the packet LSB-first on s_out under bit-stuffer backpressure, then holds endr until dpdm reports EOP sent.
// PARAMETERS
//  MAX_DATA_BYTES  8      max data payload bytes (1..64)
//  SYNC_PATTERN    8'h80  sync byte, sent LSB-first (wire order 0000_0001)
//  LEN_W           7      width of data_len; must hold MAX_DATA_BYTES
// PORTS
//  clk           in   1        clock
//  rst_n         in   1        async active-low reset
//  pkt_type      in   2        00 none, 01 data, 10 token, 11 handshake
//  pid           in   4        PID nibble; block sends {~pid,pid}
//  token_fields  in   11       {endp[3:0],addr[6:0]}, LSB-first on wire
//  data          in   8*MAX_DATA_BYTES  payload; byte0 = data[7:0] sent first
//  data_len      in   LEN_W    payload byte count (0..MAX_DATA_BYTES)
//  crc_in        in   16       external CRC (token uses [4:0]); used only without USB_PKT_CRC_EN
//  free_inbound  out  1        ready to accept a packet
//  pkt_received  out  1        1-cycle pulse: request latched
//  len_err       out  1        1-cycle pulse: data_len > MAX_DATA_BYTES, request dropped
//  pause         in   1        bit stuffer stall; current s_out bit not consumed
//  start         out  1        1-cycle pulse: start of packet to bit stuffer
//  endr          out  1        end-of-packet request, held until sent_pkt
//  s_out         out  1        serial bit
//  sent_pkt      in   1        dpdm: EOP transmitted
// BEHAVIOUR
//  - Reset (async, any state, mid-packet included): state IDLE, counters/shift reg cleared, s_out=0, start=0, endr=0,
//    pkt_received=0, len_err=0, free_inbound=1. Partial packet is discarded; no endr is issued.
//  - Sizes (bits): HS = 16; TOKEN = 32 (8+8+11+5); DATA = 32+8*data_len (8+8+payload+16).
//  - FSM IDLE -> START -> SHIFT -> EOP_WAIT -> IDLE.
//  - IDLE: free_inbound=1. pkt_type!=00 with a legal length: latch all fields and the size into the shift register/bit counter,
//    pkt_received=1 and free_inbound=0 in that cycle, go to START. If data_len>MAX: len_err=1, no pkt_received, stay in IDLE.
//  - START: start=1 for exactly one cycle, s_out = bit0 (sync bit0), pause ignored, go to SHIFT.
//  - SHIFT: s_out = current bit. pause=0 consumes the bit: shift and increment the count; pause=1 holds s_out and the count.
//    When the last bit (count==size-1) is consumed with pause=0: endr=1 in that same cycle, go to EOP_WAIT.
//    No extra idle bit after the last bit.
//  - EOP_WAIT: endr=1, s_out=0. sent_pkt=1: endr=0, go to IDLE (free_inbound=1 next cycle).
//  - sent_pkt outside EOP_WAIT and pkt_type outside IDLE are ignored; pkt_type is level-sampled only in IDLE.
//  - Zero-length data: 32 bits (SYNC, PID, CRC16 only).
//  - Bit counter width = clog2(32+8*MAX_DATA_BYTES); no wrap is possible within a packet.
//  - CRC field is sent MSB of the remainder first, per USB.
// CONFIGURATION
//  USB_PKT_CRC_EN defined:
//    - CRC computed serially as fields are shifted; crc_in is ignored.
//    - CRC5: poly x^5+x^2+1 over token_fields, init 5'h1F, result inverted.
//    - CRC16: poly 0x8005 over payload, init 16'hFFFF, result inverted.
//    - Zero extra latency; CRC is ready when the payload ends.
//  USB_PKT_CRC_EN undefined:
//    - No CRC logic; crc_in[4:0] (token) or crc_in[15:0] (data) latched at accept and sent verbatim.
//    - Handshake packets carry no CRC in either mode.
// TESTING
//  1 Handshake pid=4'h2 (ACK), pause=0 -> pkt_received 1 cycle, start 1 cycle; 16 bits on s_out = 00000001 01001011;
//    endr asserted with bit 15; sent_pkt -> IDLE.
//  2 Token pid=4'hD (SETUP), addr=0, endp=0, CRC_EN -> 32 bits; bits 16..31 = wire bytes 8'h00,8'h10 (CRC5=5'b00010).
//  3 Data pid=4'h3, data_len=0, CRC_EN -> 32 bits; CRC16 bytes = 8'h00,8'h00.
//  4 Data data_len=8; pause=1 for 3 cycles mid-payload -> s_out held 3 cycles; total consumed bits = 96; no bit lost or duplicated.
//  5 data_len=MAX+1 -> len_err pulse, no pkt_received, free_inbound stays 1. Then data_len=MAX -> accepted normally.
//  6 rst_n low mid-SHIFT -> outputs reach reset values immediately; next request produces a complete packet from SYNC.

Source files
------------

// File: rtl/usb_pkt_serializer.sv
// USB packet serializer: builds SYNC + PID/~PID + payload + CRC and streams it LSB-first to the bit stuffer.
// Define USB_PKT_CRC_EN to generate CRC5/CRC16 internally; otherwise crc_in is latched and sent verbatim.
module usb_pkt_serializer #(
   parameter int         MAX_DATA_BYTES = 8,
   parameter logic [7:0] SYNC_PATTERN   = 8'h80,
   parameter int         LEN_W          = 7
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [1:0]                  pkt_type,
   input  logic [3:0]                  pid,
   input  logic [10:0]                 token_fields,
   input  logic [8*MAX_DATA_BYTES-1:0] data,
   input  logic [LEN_W-1:0]            data_len,
   input  logic [15:0]                 crc_in,
   output logic                        free_inbound,
   output logic                        pkt_received,
   output logic                        len_err,
   input  logic                        pause,
   output logic                        start,
   output logic                        endr,
   output logic                        s_out,
   input  logic                        sent_pkt
);

   localparam int PAY_W = 8 * MAX_DATA_BYTES;
   localparam int SR_W  = 32 + PAY_W;
   localparam int CNT_W = $clog2(SR_W);

   localparam logic [1:0] PT_NONE  = 2'b00;
   localparam logic [1:0] PT_DATA  = 2'b01;
   localparam logic [1:0] PT_TOKEN = 2'b10;
   localparam logic [1:0] PT_HS    = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_SHIFT,
      ST_EOP_WAIT
   } state_t;

   state_t           state_reg;
   state_t           state_next;
   logic [SR_W-1:0]  sr_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] last_reg;

   logic             len_ok;
   logic             load_en;
   logic             consume;
   logic             cur_bit;
   logic [CNT_W-1:0] pay_bits;
   logic [CNT_W-1:0] last_load;
   logic [PAY_W-1:0] pay_mask;
   logic [15:0]      head;
   logic [PAY_W+15:0] body;
   logic [SR_W-1:0]  load_vec;

   // Only data packets carry a length; oversize requests are rejected in IDLE.
   assign len_ok   = (pkt_type != PT_DATA) || (data_len <= LEN_W'(MAX_DATA_BYTES));
   assign pay_bits = CNT_W'({data_len, 3'b000});
   assign head     = {~pid, pid, SYNC_PATTERN};

   genvar gi;
   generate
      for (gi = 0; gi < PAY_W; gi++) begin : g_pay_mask
         assign pay_mask[gi] = (CNT_W'(gi) < pay_bits);
      end
   endgenerate

`ifndef USB_PKT_CRC_EN
   // External CRC goes out MSB first, so it is stored bit-reversed behind the fields.
   logic [15:0] crc16_rev;
   logic [4:0]  crc5_rev;

   generate
      for (gi = 0; gi < 16; gi++) begin : g_crc16_rev
         assign crc16_rev[gi] = crc_in[15-gi];
      end
      for (gi = 0; gi < 5; gi++) begin : g_crc5_rev
         assign crc5_rev[gi] = crc_in[4-gi];
      end
   endgenerate
`endif

   always_comb begin
      body      = '0;
      last_load = CNT_W'(15);
      case (pkt_type)
         PT_TOKEN: begin
            body[10:0] = token_fields;
`ifndef USB_PKT_CRC_EN
            body[15:11] = crc5_rev;
`endif
            last_load = CNT_W'(31);
         end
         PT_DATA: begin
            body[PAY_W-1:0] = data & pay_mask;
`ifndef USB_PKT_CRC_EN
            body = body | ({{PAY_W{1'b0}}, crc16_rev} << pay_bits);
`endif
            last_load = CNT_W'(31) + pay_bits;
         end
         PT_HS: begin
            last_load = CNT_W'(15);
         end
         default: begin
            last_load = CNT_W'(15);
         end
      endcase
   end

   assign load_vec = {body, head};

`ifdef USB_PKT_CRC_EN
   logic [1:0]       ptype_reg;
   logic [CNT_W-1:0] crc_start_reg;
   logic [CNT_W-1:0] crc_start_load;
   logic [4:0]       crc5_reg;
   logic [15:0]      crc16_reg;
   logic             in_crc;
   logic             feed_crc;
   logic             fb5;
   logic             fb16;

   assign crc_start_load = (pkt_type == PT_TOKEN) ? CNT_W'(27) : (CNT_W'(16) + pay_bits);
   assign in_crc   = (ptype_reg != PT_HS) && (cnt_reg >= crc_start_reg);
   assign feed_crc = (ptype_reg != PT_HS) && (cnt_reg >= CNT_W'(16)) && !in_crc;
   assign fb5      = sr_reg[0] ^ crc5_reg[4];
   assign fb16     = sr_reg[0] ^ crc16_reg[15];
   // The remainder is shifted out MSB first and inverted on the fly.
   assign cur_bit  = in_crc ? ~((ptype_reg == PT_TOKEN) ? crc5_reg[4] : crc16_reg[15]) : sr_reg[0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptype_reg     <= PT_NONE;
         crc_start_reg <= '0;
         crc5_reg      <= '0;
         crc16_reg     <= '0;
      end else if (load_en) begin
         ptype_reg     <= pkt_type;
         crc_start_reg <= crc_start_load;
         crc5_reg      <= 5'h1F;
         crc16_reg     <= 16'hFFFF;
      end else if (consume) begin
         if (in_crc) begin
            crc5_reg  <= {crc5_reg[3:0], 1'b0};
            crc16_reg <= {crc16_reg[14:0], 1'b0};
         end else if (feed_crc) begin
            if (ptype_reg == PT_TOKEN) begin
               crc5_reg <= {crc5_reg[3:0], 1'b0} ^ (fb5 ? 5'h05 : 5'h00);
            end else begin
               crc16_reg <= {crc16_reg[14:0], 1'b0} ^ (fb16 ? 16'h8005 : 16'h0000);
            end
         end
      end
   end
`else
   assign cur_bit = sr_reg[0];
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
         sr_reg    <= '0;
         cnt_reg   <= '0;
         last_reg  <= '0;
      end else begin
         state_reg <= state_next;
         if (load_en) begin
            sr_reg   <= load_vec;
            cnt_reg  <= '0;
            last_reg <= last_load;
         end else if (consume) begin
            sr_reg  <= {1'b0, sr_reg[SR_W-1:1]};
            cnt_reg <= cnt_reg + CNT_W'(1);
         end
      end
   end

   always_comb begin
      state_next   = state_reg;
      free_inbound = 1'b0;
      pkt_received = 1'b0;
      len_err      = 1'b0;
      start        = 1'b0;
      endr         = 1'b0;
      s_out        = 1'b0;
      load_en      = 1'b0;
      consume      = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            free_inbound = 1'b1;
            if (pkt_type != PT_NONE) begin
               if (!len_ok) begin
                  len_err = 1'b1;
               end else begin
                  pkt_received = 1'b1;
                  free_inbound = 1'b0;
                  load_en      = 1'b1;
                  state_next   = ST_START;
               end
            end
         end
         ST_START: begin
            // Bit 0 is only presented here; SHIFT consumes every bit including it.
            start      = 1'b1;
            s_out      = cur_bit;
            state_next = ST_SHIFT;
         end
         ST_SHIFT: begin
            s_out = cur_bit;
            if (!pause) begin
               consume = 1'b1;
               if (cnt_reg == last_reg) begin
                  endr       = 1'b1;
                  state_next = ST_EOP_WAIT;
               end
            end
         end
         ST_EOP_WAIT: begin
            if (sent_pkt) begin
               state_next = ST_IDLE;
            end else begin
               endr = 1'b1;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_usb_pkt_serializer.sv
// Self-checking bench for usb_pkt_serializer: known-vector table, directed corner sequences and randomized packets.
module tb_usb_pkt_serializer;

   localparam int MAX   = 8;
   localparam int LEN_W = 7;
   localparam int PAY_W = 8 * MAX;
   localparam logic [7:0] SYNC = 8'h80;
   localparam logic [1:0] T_DATA  = 2'b01;
   localparam logic [1:0] T_TOKEN = 2'b10;
   localparam logic [1:0] T_HS    = 2'b11;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [1:0]       pkt_type;
   logic [3:0]       pid;
   logic [10:0]      token_fields;
   logic [PAY_W-1:0] data;
   logic [LEN_W-1:0] data_len;
   logic [15:0]      crc_in;
   logic             free_inbound;
   logic             pkt_received;
   logic             len_err;
   logic             pause;
   logic             start;
   logic             endr;
   logic             s_out;
   logic             sent_pkt;

   usb_pkt_serializer #(
      .MAX_DATA_BYTES(MAX),
      .SYNC_PATTERN  (SYNC),
      .LEN_W         (LEN_W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pkt_type    (pkt_type),
      .pid         (pid),
      .token_fields(token_fields),
      .data        (data),
      .data_len    (data_len),
      .crc_in      (crc_in),
      .free_inbound(free_inbound),
      .pkt_received(pkt_received),
      .len_err     (len_err),
      .pause       (pause),
      .start       (start),
      .endr        (endr),
      .s_out       (s_out),
      .sent_pkt    (sent_pkt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]       t;
      logic [3:0]       p;
      logic [10:0]      tok;
      logic [PAY_W-1:0] d;
      logic [LEN_W-1:0] len;
      logic [15:0]      crc;
   } pkt_t;

   typedef struct {
      pkt_t        pk;
      int          exp_nb;
      logic [31:0] exp_lo;
   } vec_t;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reflected (LSB-first) forms of the USB CRCs; transmitted low bit first.
   function automatic logic [4:0] crc5_ref(input logic [10:0] v);
      logic [4:0] c = 5'h1F;
      for (int i = 0; i < 11; i++) c = (c[0] ^ v[i]) ? ((c >> 1) ^ 5'h14) : (c >> 1);
      return ~c;
   endfunction

   function automatic logic [15:0] crc16_ref(input logic [PAY_W-1:0] d, input int nbits);
      logic [15:0] c = 16'hFFFF;
      for (int i = 0; i < nbits; i++) c = (c[0] ^ d[i]) ? ((c >> 1) ^ 16'hA001) : (c >> 1);
      return ~c;
   endfunction

   function automatic void model(input pkt_t pk, output int nb, output logic [127:0] bits);
      bit         q[$];
      logic [7:0] sy;
      logic [7:0] pb;
      logic [4:0] c5;
      logic [15:0] c16;
      sy = SYNC;
      pb = {~pk.p, pk.p};
      for (int i = 0; i < 8; i++) q.push_back(sy[i]);
      for (int i = 0; i < 8; i++) q.push_back(pb[i]);
      if (pk.t == T_TOKEN) begin
         for (int i = 0; i < 11; i++) q.push_back(pk.tok[i]);
`ifdef USB_PKT_CRC_EN
         c5 = crc5_ref(pk.tok);
`else
         for (int i = 0; i < 5; i++) c5[i] = pk.crc[4-i];
`endif
         for (int i = 0; i < 5; i++) q.push_back(c5[i]);
      end else if (pk.t == T_DATA) begin
         for (int i = 0; i < 8 * int'(pk.len); i++) q.push_back(pk.d[i]);
`ifdef USB_PKT_CRC_EN
         c16 = crc16_ref(pk.d, 8 * int'(pk.len));
`else
         for (int i = 0; i < 16; i++) c16[i] = pk.crc[15-i];
`endif
         for (int i = 0; i < 16; i++) q.push_back(c16[i]);
      end
      nb   = q.size();
      bits = '0;
      foreach (q[i]) bits[i] = q[i];
   endfunction

   // pmode: 0 no stall, 1 random stalls/noise on ignored inputs, 2 three-cycle stall mid-payload.
   task automatic run_pkt(input pkt_t pk, input int pmode, output int nb, output logic [127:0] got);
      int   cyc;
      int   nheld;
      logic held0;
      nb    = 0;
      got   = '0;
      nheld = 0;
      held0 = 1'b0;
      @(posedge clk); #1;
      pkt_type = 2'b00; pause = 1'b0; sent_pkt = 1'b0;
      @(negedge clk);
      chk("idle_free", 128'(free_inbound), 128'(1));
      @(posedge clk); #1;
      pkt_type = pk.t; pid = pk.p; token_fields = pk.tok; data = pk.d; data_len = pk.len; crc_in = pk.crc;
      @(negedge clk);
      chk("accept", 128'({pkt_received, free_inbound, len_err}), 128'(3'b100));
      @(posedge clk); #1;
      if (pmode == 1) begin
         pkt_type = 2'($urandom_range(1, 3));
         pid = 4'($urandom); token_fields = 11'($urandom); crc_in = 16'($urandom);
         data = {$urandom, $urandom};
         pause = 1'($urandom_range(0, 1));
      end else begin
         pkt_type = 2'b00;
      end
      @(negedge clk);
      chk("start_cycle", 128'({start, s_out, pkt_received}), 128'(3'b100));
      cyc = 0;
      while (1) begin
         @(posedge clk); #1;
         case (pmode)
            1: begin
               pause    = ($urandom_range(0, 3) == 0);
               sent_pkt = ($urandom_range(0, 7) == 0);
            end
            2: pause = (cyc >= 40 && cyc <= 42);
            default: pause = 1'b0;
         endcase
         @(negedge clk);
         if (cyc == 0) chk("start_pulse", 128'(start), 128'(0));
         if (pmode == 2 && cyc == 40) held0 = s_out;
         if (pmode == 2 && cyc >= 41 && cyc <= 43 && s_out == held0) nheld++;
         if (!pause) begin
            if (nb < 128) got[nb] = s_out;
            nb++;
         end
         if (endr) break;
         cyc++;
         if (cyc > 2000) begin
            chk("endr_timeout", 128'(endr), 128'(1));
            return;
         end
      end
      if (pmode == 2) chk("pause_hold", 128'(nheld), 128'(3));
      @(posedge clk); #1;
      pause = 1'b0; sent_pkt = 1'b0; pkt_type = 2'b00;
      @(negedge clk);
      chk("eop_wait", 128'({endr, s_out, free_inbound}), 128'(3'b100));
      @(posedge clk); #1;
      sent_pkt = 1'b1;
      @(posedge clk); #1;
      sent_pkt = 1'b0;
      @(negedge clk);
      chk("back_idle", 128'({endr, free_inbound}), 128'(2'b01));
      $display("pkt type=%0d pid=%0h len=%0d mode=%0d bits=%0d", pk.t, pk.p, pk.len, pmode, nb);
   endtask

   task automatic check_pkt(input string tag, input pkt_t pk, input int pmode);
      int           nb;
      int           enb;
      logic [127:0] got;
      logic [127:0] exp;
      run_pkt(pk, pmode, nb, got);
      model(pk, enb, exp);
      chk({tag, "_nbits"}, 128'(nb), 128'(enb));
      chk({tag, "_bits"}, got, exp);
   endtask

   function automatic pkt_t rand_pkt(input int len);
      pkt_t pk;
      pk.t   = 2'($urandom_range(1, 3));
      pk.p   = 4'($urandom);
      pk.tok = 11'($urandom);
      pk.d   = {$urandom, $urandom};
      pk.len = LEN_W'(len);
      pk.crc = 16'($urandom);
      return pk;
   endfunction

   initial begin
      vec_t         vt[5];
      pkt_t         pk;
      int           nb;
      logic [127:0] got;
      logic [127:0] exp;
      int           enb;

      // Known wire images (bit k of exp_lo = k-th bit on s_out).
      vt[0] = '{pk: '{t: T_HS,    p: 4'h2, tok: 11'h0, d: '0, len: '0, crc: 16'h0000}, exp_nb: 16, exp_lo: 32'h0000D280};
      vt[1] = '{pk: '{t: T_TOKEN, p: 4'hD, tok: 11'h0, d: '0, len: '0, crc: 16'h0008}, exp_nb: 32, exp_lo: 32'h10002D80};
      vt[2] = '{pk: '{t: T_DATA,  p: 4'h3, tok: 11'h0, d: '0, len: '0, crc: 16'h0000}, exp_nb: 32, exp_lo: 32'h0000C380};
      vt[3] = '{pk: '{t: T_HS,    p: 4'hA, tok: 11'h0, d: '0, len: '0, crc: 16'h0000}, exp_nb: 16, exp_lo: 32'h00005A80};
      vt[4] = '{pk: '{t: T_HS,    p: 4'hE, tok: 11'h0, d: '0, len: '0, crc: 16'h0000}, exp_nb: 16, exp_lo: 32'h00001E80};

      rst_n = 1'b0; pkt_type = 2'b00; pid = 4'h0; token_fields = '0; data = '0;
      data_len = '0; crc_in = '0; pause = 1'b0; sent_pkt = 1'b0;
      #2;
      chk("reset_outputs", 128'({s_out, start, endr, pkt_received, len_err, free_inbound}), 128'(6'b000001));
      @(posedge clk); #3;
      rst_n = 1'b1;

      for (int i = 0; i < 5; i++) begin
         run_pkt(vt[i].pk, 0, nb, got);
         model(vt[i].pk, enb, exp);
         chk($sformatf("vec%0d_nbits", i), 128'(nb), 128'(vt[i].exp_nb));
         chk($sformatf("vec%0d_word", i), 128'(got[31:0]), 128'(vt[i].exp_lo));
         chk($sformatf("vec%0d_model", i), got, exp);
      end

      // Full-length data with a three-cycle stall inside the payload.
      pk = rand_pkt(MAX);
      pk.t = T_DATA;
      check_pkt("stall_data", pk, 2);

      // Oversize request is dropped, then the maximum length goes through.
      @(posedge clk); #1;
      pkt_type = T_DATA; data_len = LEN_W'(MAX + 1);
      @(negedge clk);
      chk("len_err", 128'({len_err, pkt_received, free_inbound}), 128'(3'b101));
      @(posedge clk); #1;
      pkt_type = 2'b00;
      @(negedge clk);
      chk("len_err_pulse", 128'({len_err, free_inbound}), 128'(2'b01));
      $display("pkt type=%0d len=%0d rejected", T_DATA, MAX + 1);
      pk = rand_pkt(MAX);
      pk.t = T_DATA;
      check_pkt("max_len", pk, 0);

      // Asynchronous reset in the middle of a packet.
      @(posedge clk); #1;
      pkt_type = T_DATA; pid = 4'h3; data = {$urandom, $urandom}; data_len = LEN_W'(MAX);
      @(posedge clk); #1;
      pkt_type = 2'b00;
      repeat (12) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_reset", 128'({s_out, start, endr, pkt_received, len_err, free_inbound}), 128'(6'b000001));
      $display("pkt reset mid-shift");
      @(posedge clk); #3;
      rst_n = 1'b1;
      pk = rand_pkt(int'($urandom_range(0, MAX)));
      pk.t = T_DATA;
      check_pkt("after_reset", pk, 0);

      for (int i = 0; i < 40; i++) begin
         pk = rand_pkt(int'($urandom_range(0, MAX)));
         check_pkt($sformatf("rand%0d", i), pk, int'($urandom_range(0, 1)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, got no summary expected one");
      $fatal(1, "watchdog");
   end

endmodule
